// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a wrapping address range of the register bank and streams each word out
// over a valid/ready interface.
//   Clk, Rst            clock, synchronous active-high reset
//   Start               dump request, accepted only when idle
//   First_reg, Last_reg inclusive address range, latched on an accepted Start (wraps 31->0)
//   Busy                high while a dump is in progress
//   Rd_reg, Rd_data     registered address to the bank read port, combinational data back
//   Out_valid/Out_ready output handshake; Out_data, Out_addr, Out_last describe the word
//   Done                one-cycle pulse after the final handshake
// Optional feature: define REG_DUMP_CHECKSUM_EN to append an XOR checksum word after the last
// register word. Without it, Out_last marks the final register word.
module reg_dump_reader #(
    parameter int N_ADDR = 5,
    parameter int N_REG  = 32,
    parameter int N_BIT  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [N_ADDR-1:0] First_reg,
    input  logic [N_ADDR-1:0] Last_reg,
    output logic              Busy,
    output logic [N_ADDR-1:0] Rd_reg,
    input  logic [N_BIT-1:0]  Rd_data,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [N_BIT-1:0]  Out_data,
    output logic [N_ADDR-1:0] Out_addr,
    output logic              Out_last,
    output logic              Done
);
`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, READ, SEND, CSUM} state_t;
    logic [N_BIT-1:0] csum, csum_n;
`else
    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;
`endif
    state_t state, state_n;
    logic [N_ADDR-1:0] last_q, last_n, rd_reg_n, addr_n;
    logic [N_BIT-1:0]  data_n;
    logic busy_n, valid_n, olast_n, done_n, hs;

    assign hs = Out_valid && Out_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            last_q    <= '0;
            Rd_reg    <= '0;
            Busy      <= 1'b0;
            Out_valid <= 1'b0;
            Out_data  <= '0;
            Out_addr  <= '0;
            Out_last  <= 1'b0;
            Done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_n;
            last_q    <= last_n;
            Rd_reg    <= rd_reg_n;
            Busy      <= busy_n;
            Out_valid <= valid_n;
            Out_data  <= data_n;
            Out_addr  <= addr_n;
            Out_last  <= olast_n;
            Done      <= done_n;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= csum_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        last_n   = last_q;
        rd_reg_n = Rd_reg;
        busy_n   = Busy;
        valid_n  = Out_valid;
        data_n   = Out_data;
        addr_n   = Out_addr;
        olast_n  = Out_last;
        done_n   = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_n   = csum;
`endif
        case (state)
            IDLE: if (Start) begin
                last_n   = Last_reg;
                rd_reg_n = First_reg;
                busy_n   = 1'b1;
                state_n  = READ;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_n   = '0;
`endif
            end
            READ: begin
                data_n  = Rd_data;
                addr_n  = Rd_reg;
                valid_n = 1'b1;
                state_n = SEND;
`ifdef REG_DUMP_CHECKSUM_EN
                olast_n = 1'b0;
                csum_n  = csum ^ Rd_data;
`else
                olast_n = (Rd_reg == last_q);
`endif
            end
            SEND: if (hs) begin
                if (Rd_reg != last_q) begin
                    valid_n  = 1'b0;
                    rd_reg_n = N_ADDR'((int'(Rd_reg) + 1) % N_REG);
                    state_n  = READ;
                end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                    // Out_valid stays high: the checksum word follows immediately
                    data_n  = csum;
                    addr_n  = last_q;
                    olast_n = 1'b1;
                    state_n = CSUM;
`else
                    busy_n  = 1'b0;
                    valid_n = 1'b0;
                    olast_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: if (hs) begin
                busy_n  = 1'b0;
                valid_n = 1'b0;
                olast_n = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule
